div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for the EX stage. Issues stall requests
//  to the pipeline controller: drives the EX stall request high while a division
//  is in flight and releases it the cycle the result is ready. EX holds start_i

---
 rtl/div_unit_if.sv | 37 +++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-stage to divider handshake bundle
// DIV_ZERO_FLAG_EN adds the div_zero_o flag to the bundle.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   stallreq_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                   div_zero_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o, div_zero_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o, div_zero_o
    );
`else
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
`endif
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider with EX stall request
// Optional feature macro: DIV_ZERO_FLAG_EN (registered divide-by-zero flag).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
`ifdef DIV_ZERO_FLAG_EN
    logic                 div_zero_q, div_zero_d;
`endif

    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic                 op1_neg;
    logic                 op2_neg;

    // dvd_q starts as |dividend| and fills with quotient bits from the LSB
    // as dividend bits leave from the MSB into the partial remainder.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        q_bit     = ~diff[WIDTH];
        rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {dvd_q[WIDTH-2:0], q_bit};
        op1_neg   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        op2_neg   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        ready_d    = ready_q;
        result_d   = result_q;
`ifdef DIV_ZERO_FLAG_EN
        div_zero_d = div_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    cnt_d = '0;
                    rem_d = '0;
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_ON;
                        dvd_d     = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
                        dvs_d     = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
                        quo_neg_d = op1_neg ^ op2_neg;
                        rem_neg_d = op1_neg;
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                ready_d  = 1'b1;
                result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
                div_zero_d = 1'b1;
`endif
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_next;
                    dvd_d = quo_next;
                    cnt_d = cnt_q + CW'(1);
                    // Last quotient bit: apply the sign fix-up straight into the result.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {rem_neg_q ? -rem_next : rem_next,
                                    quo_neg_q ? -quo_next : quo_next};
                    end
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
// Checks div_zero_o too when built with DIV_ZERO_FLAG_EN.
module tb_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus ();
    div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] result;
        int             lat;
        logic           dz;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_op(input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r);
        exp_t e;
        e.result = (b == '0) ? '0 : {r, q};
        e.lat    = (b == '0) ? 2 : W + 1;
        e.dz     = (b == '0);
        sb.push_back(e);
    endtask

    task automatic drive(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
    endtask

    // Called just after a falling edge with start_i high: that cycle is t (n=0).
    task automatic await_result(input string name);
        exp_t e;
        int   n = 0;
        int   stall_cnt = 0;
        #1;
        while (!bus.ready_o && n < 3 * W) begin
            if (bus.stallreq_o) stall_cnt++;
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom;
            end
            #1;
        end
        e = sb.pop_front();
        check({name, " ready"}, 64'(bus.ready_o), 64'(1));
        check({name, " latency"}, 64'(n), 64'(e.lat));
        check({name, " stall_cycles"}, 64'(stall_cnt), 64'(e.lat));
        check({name, " stall_end"}, 64'(bus.stallreq_o), 64'(0));
        check({name, " result"}, bus.result_o, e.result);
`ifdef DIV_ZERO_FLAG_EN
        check({name, " div_zero"}, 64'(bus.div_zero_o), 64'(e.dz));
`endif
        @(negedge clk);
        #1;
        check({name, " hold_ready"}, 64'(bus.ready_o), 64'(1));
        check({name, " hold_result"}, bus.result_o, e.result);
        bus.start_i = 1'b0;
        @(negedge clk);
        #1;
        check({name, " drop_ready"}, 64'(bus.ready_o), 64'(0));
        check({name, " drop_result"}, bus.result_o, 64'(0));
`ifdef DIV_ZERO_FLAG_EN
        check({name, " drop_div_zero"}, 64'(bus.div_zero_o), 64'(0));
`endif
    endtask

    initial begin
        #1ms;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
        vecs[3]  = '{1'b0, 32'd12345,      32'd0,        32'h00000000, 32'h00000000};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'h00000000};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[8]  = '{1'b0, 32'd5,          32'd10,       32'h00000000, 32'h00000005};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE};
        vecs[10] = '{1'b0, 32'h80000000,   32'd3,        32'h2AAAAAAA, 32'h00000002};
        vecs[11] = '{1'b1, 32'd0,          32'd0,        32'h00000000, 32'h00000000};
        vecs[12] = '{1'b0, 32'hFFFFFFFF,   32'h00010000, 32'h0000FFFF, 32'h0000FFFF};
        vecs[13] = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'h00000001};

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset ready", 64'(bus.ready_o), 64'(0));
        check("reset result", bus.result_o, 64'(0));
        check("reset stall", 64'(bus.stallreq_o), 64'(0));
`ifdef DIV_ZERO_FLAG_EN
        check("reset div_zero", 64'(bus.div_zero_o), 64'(0));
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            expect_op(vecs[i].b, vecs[i].q, vecs[i].r);
            drive(vecs[i].sgn, vecs[i].a, vecs[i].b);
            await_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ua, ub;
            ua = $urandom;
            ub = $urandom >> $urandom_range(0, 31);
            if (ub == '0) ub = 32'd1;
            expect_op(ub, ua / ub, ua % ub);
            drive(1'b0, ua, ub);
            await_result($sformatf("rand_u%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            int sa, sd;
            sa = int'($urandom);
            sd = int'($urandom) >>> $urandom_range(0, 30);
            if (sd == 0 || sd == -1) sd = 3;
            expect_op(sd, sa / sd, sa % sd);
            drive(1'b1, sa, sd);
            await_result($sformatf("rand_s%0d", i));
        end

        // Flush at ON cycle 10, then an immediate new request.
        drive(1'b1, 32'hFFFFFF9C, 32'd7);
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        #1;
        check("annul stall", 64'(bus.stallreq_o), 64'(0));
        check("annul ready", 64'(bus.ready_o), 64'(0));
        @(negedge clk);
        bus.annul_i = 1'b0;
        #1;
        check("annul no_ready", 64'(bus.ready_o), 64'(0));
        check("annul no_result", bus.result_o, 64'(0));
        expect_op(32'd33, 32'd30, 32'd10);
        drive(1'b0, 32'd1000, 32'd33);
        await_result("after_annul");

        // Reset at ON cycle 5 with start held: restarts at full latency.
        drive(1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst ready", 64'(bus.ready_o), 64'(0));
        check("midrst result", bus.result_o, 64'(0));
        expect_op(32'd7, 32'd14, 32'd2);
        await_result("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
